// File: rtl/qdma_h2c_pkt_buffer.sv
// Store-and-forward buffer from QDMA H2C beats to the user pipeline: drops errored,
// zero-byte and oversized packets, emits whole packets with OpenNIC-style tuser.
module qdma_h2c_pkt_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int BUF_AW     = 6,
  parameter int DESC_AW    = 3
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_h2c_tdata,
  input  logic                  s_axis_h2c_tvalid,
  output logic                  s_axis_h2c_tready,
  input  logic                  s_axis_h2c_tlast,
  input  logic [5:0]            s_axis_h2c_tuser_mty,
  input  logic                  s_axis_h2c_tuser_err,
  input  logic                  s_axis_h2c_tuser_zero_byte,
  input  logic [10:0]           s_axis_h2c_tuser_qid,
  input  logic [2:0]            s_axis_h2c_tuser_port_id,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tuser_size,
  output logic [15:0]           m_axis_tuser_src,
  output logic [15:0]           m_axis_tuser_dst,
  output logic [31:0]           stat_pkt_in,
  output logic [31:0]           stat_pkt_drop
);

  localparam int BUF_DEPTH  = 1 << BUF_AW;
  localparam int DESC_DEPTH = 1 << DESC_AW;
  localparam int RAM_W      = DATA_WIDTH + 7;
  localparam logic [BUF_AW:0] BEAT_LIMIT = BUF_DEPTH[BUF_AW:0] - 1'b1;
  localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = '1;

  typedef enum logic [1:0] {WR_IDLE, WR_BODY, WR_DROP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic [RAM_W-1:0] beat_ram [BUF_DEPTH];
  logic [47:0]      desc_ram [DESC_DEPTH];

  logic [BUF_AW:0]  spec_wr_ptr, commit_wr_ptr, rd_ptr;
  logic [DESC_AW:0] desc_wr_ptr, desc_rd_ptr;
  logic [BUF_AW:0]  beat_cnt;
  logic             err_acc;
  logic [10:0]      qid_q;
  logic [2:0]       port_q;

  logic ram_full, desc_full, desc_empty;
  logic in_hs, out_hs, at_limit, err_now;
  logic ram_we, first_beat, commit, drop_pkt, rewind;
  logic load_first, load_next, pop;
  logic [BUF_AW:0]  prev_beats;
  logic [10:0]      cur_qid;
  logic [2:0]       cur_port;
  logic [15:0]      pkt_size, pkt_src, pkt_dst;
  logic [RAM_W-1:0] rd_word;

  // Occupancy is judged from registered pointers only, so a freed slot re-opens tready a cycle later.
  assign ram_full   = (spec_wr_ptr[BUF_AW] != rd_ptr[BUF_AW]) &&
                      (spec_wr_ptr[BUF_AW-1:0] == rd_ptr[BUF_AW-1:0]);
  assign desc_full  = (desc_wr_ptr[DESC_AW] != desc_rd_ptr[DESC_AW]) &&
                      (desc_wr_ptr[DESC_AW-1:0] == desc_rd_ptr[DESC_AW-1:0]);
  assign desc_empty = (desc_wr_ptr == desc_rd_ptr);

  assign s_axis_h2c_tready = axis_rst ? 1'b0 :
                             (wr_state == WR_DROP) ? 1'b1 : (!ram_full && !desc_full);
  assign in_hs    = s_axis_h2c_tvalid && s_axis_h2c_tready;
  assign at_limit = (beat_cnt == BEAT_LIMIT);
  assign err_now  = s_axis_h2c_tuser_err | s_axis_h2c_tuser_zero_byte |
                    ((wr_state == WR_BODY) && err_acc);

  // Single-beat packets resolve in IDLE, so sideband comes straight from the bus there.
  assign cur_qid    = (wr_state == WR_IDLE) ? s_axis_h2c_tuser_qid : qid_q;
  assign cur_port   = (wr_state == WR_IDLE) ? s_axis_h2c_tuser_port_id : port_q;
  assign prev_beats = (wr_state == WR_BODY) ? beat_cnt : '0;
  assign pkt_size   = 16'(prev_beats) * 16'(KEEP_WIDTH) + 16'(KEEP_WIDTH) -
                      {10'd0, s_axis_h2c_tuser_mty};
  assign pkt_src    = {2'b00, cur_port, cur_qid};
  assign pkt_dst    = 16'h0040 << cur_port;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) wr_state <= WR_IDLE;
    else          wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_IDLE: if (in_hs && !s_axis_h2c_tlast) wr_state_next = WR_BODY;
      WR_BODY: begin
        if (in_hs) begin
          if (s_axis_h2c_tlast) wr_state_next = WR_IDLE;
          else if (at_limit)    wr_state_next = WR_DROP;
        end
      end
      WR_DROP: if (in_hs && s_axis_h2c_tlast) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    first_beat = 1'b0;
    commit     = 1'b0;
    drop_pkt   = 1'b0;
    rewind     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (in_hs) begin
          ram_we     = 1'b1;
          first_beat = 1'b1;
          if (s_axis_h2c_tlast) begin
            commit   = !err_now;
            drop_pkt = err_now;
            rewind   = err_now;
          end
        end
      end
      WR_BODY: begin
        if (in_hs) begin
          if (s_axis_h2c_tlast) begin
            ram_we   = 1'b1;
            commit   = !err_now;
            drop_pkt = err_now;
            rewind   = err_now;
          end else if (at_limit) begin
            rewind = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
        end
      end
      WR_DROP: drop_pkt = in_hs && s_axis_h2c_tlast;
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      spec_wr_ptr   <= '0;
      commit_wr_ptr <= '0;
      desc_wr_ptr   <= '0;
      beat_cnt      <= '0;
      err_acc       <= 1'b0;
      qid_q         <= '0;
      port_q        <= '0;
      stat_pkt_in   <= '0;
      stat_pkt_drop <= '0;
    end else begin
      if (ram_we) spec_wr_ptr <= spec_wr_ptr + 1'b1;
      if (rewind) spec_wr_ptr <= commit_wr_ptr;
      if (commit) begin
        commit_wr_ptr <= spec_wr_ptr + 1'b1;
        desc_wr_ptr   <= desc_wr_ptr + 1'b1;
      end
      if (first_beat) begin
        qid_q    <= s_axis_h2c_tuser_qid;
        port_q   <= s_axis_h2c_tuser_port_id;
        err_acc  <= s_axis_h2c_tuser_err | s_axis_h2c_tuser_zero_byte;
        beat_cnt <= {{BUF_AW{1'b0}}, 1'b1};
      end else if ((wr_state == WR_BODY) && in_hs) begin
        err_acc  <= err_acc | s_axis_h2c_tuser_err | s_axis_h2c_tuser_zero_byte;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (commit && (stat_pkt_in != 32'hFFFF_FFFF))     stat_pkt_in   <= stat_pkt_in + 32'd1;
      if (drop_pkt && (stat_pkt_drop != 32'hFFFF_FFFF)) stat_pkt_drop <= stat_pkt_drop + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (ram_we)
      beat_ram[spec_wr_ptr[BUF_AW-1:0]] <= {s_axis_h2c_tdata, s_axis_h2c_tlast, s_axis_h2c_tuser_mty};
    if (commit)
      desc_ram[desc_wr_ptr[DESC_AW-1:0]] <= {pkt_size, pkt_src, pkt_dst};
  end

  assign rd_word = beat_ram[rd_ptr[BUF_AW-1:0]];
  assign out_hs  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) rd_state <= RD_IDLE;
    else          rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (!desc_empty) rd_state_next = RD_SEND;
      RD_SEND: if (out_hs && m_axis_tlast) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    load_first = (rd_state == RD_IDLE) && !desc_empty;
    load_next  = (rd_state == RD_SEND) && out_hs && !m_axis_tlast;
    pop        = (rd_state == RD_SEND) && out_hs && m_axis_tlast;
  end

  // Output registers only move on a load, so everything holds while the sink stalls.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      rd_ptr            <= '0;
      desc_rd_ptr       <= '0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_src  <= '0;
      m_axis_tuser_dst  <= '0;
    end else begin
      if (load_first || load_next) begin
        m_axis_tdata  <= rd_word[RAM_W-1:7];
        m_axis_tlast  <= rd_word[6];
        m_axis_tkeep  <= rd_word[6] ? (KEEP_ALL >> rd_word[5:0]) : KEEP_ALL;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (load_first)
        {m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst} <= desc_ram[desc_rd_ptr[DESC_AW-1:0]];
      if (pop) begin
        m_axis_tvalid <= 1'b0;
        desc_rd_ptr   <= desc_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qdma_h2c_pkt_buffer.sv
// Self-checking bench for qdma_h2c_pkt_buffer: directed and random packets checked
// against a packet-level reference model (fate, beats, keep, tuser, counters).
module tb_qdma_h2c_pkt_buffer;

  localparam int DW = 512;
  localparam int KW = 64;

  typedef logic [DW-1:0] word_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   size;
    logic [15:0]   src;
    logic [15:0]   dst;
  } beat_t;

  logic          clk = 1'b0;
  logic          axis_rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_err, s_zb;
  logic [5:0]    s_mty;
  logic [10:0]   s_qid;
  logic [2:0]    s_port;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [15:0]   m_size, m_src, m_dst;
  logic [31:0]   stat_in, stat_drop;

  beat_t exp_q[$];
  int    tests = 0;
  int    failed = 0;
  int    exp_in = 0;
  int    exp_drop = 0;
  bit    stim_done;

  always #5 clk = ~clk;

  qdma_h2c_pkt_buffer dut (
    .axis_aclk                  (clk),
    .axis_rst                   (axis_rst),
    .s_axis_h2c_tdata           (s_tdata),
    .s_axis_h2c_tvalid          (s_tvalid),
    .s_axis_h2c_tready          (s_tready),
    .s_axis_h2c_tlast           (s_tlast),
    .s_axis_h2c_tuser_mty       (s_mty),
    .s_axis_h2c_tuser_err       (s_err),
    .s_axis_h2c_tuser_zero_byte (s_zb),
    .s_axis_h2c_tuser_qid       (s_qid),
    .s_axis_h2c_tuser_port_id   (s_port),
    .m_axis_tdata               (m_tdata),
    .m_axis_tkeep               (m_tkeep),
    .m_axis_tvalid              (m_tvalid),
    .m_axis_tready              (m_tready),
    .m_axis_tlast               (m_tlast),
    .m_axis_tuser_size          (m_size),
    .m_axis_tuser_src           (m_src),
    .m_axis_tuser_dst           (m_dst),
    .stat_pkt_in                (stat_in),
    .stat_pkt_drop              (stat_drop)
  );

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [KW-1:0] keepOf(input int nbytes);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < KW; i++)
      if (i < nbytes) k[i] = 1'b1;
    return k;
  endfunction

  // Drives one packet beat by beat; stop_after>0 abandons it after that many beats.
  task automatic applyStimulus(input int nbeats, input int last_mty, input int qid, input int port,
                               input int err_beat, input bit zb, input int stop_after,
                               output int stalls);
    logic [DW-1:0] beats[$];
    logic [DW-1:0] d;
    bit            ok;
    bit            partial;
    bit            drop;
    int            waited;
    beat_t         e;
    stalls  = 0;
    partial = (stop_after > 0) && (stop_after < nbeats);
    @(posedge clk); #1;
    for (int b = 0; b < nbeats; b++) begin
      if (partial && b == stop_after) break;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = (b == nbeats - 1);
      s_mty    = (b == nbeats - 1) ? 6'(last_mty) : 6'($urandom());
      s_err    = (b == err_beat);
      s_zb     = zb && (b == 0);
      s_qid    = (b == 0) ? 11'(qid) : 11'($urandom());
      s_port   = (b == 0) ? 3'(port) : 3'($urandom());
      beats.push_back(d);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 2000) begin
        @(negedge clk);
        ok = s_tready;
        @(posedge clk); #1;
        waited++;
      end
      if (!ok) checkOutput("input_timeout", word_t'(ok), word_t'(1));
      stalls += waited - 1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_err    = 1'b0;
    s_zb     = 1'b0;
    if (!partial) begin
      drop = (err_beat >= 0 && err_beat < nbeats) || zb || (nbeats > 64);
      if (drop) exp_drop++;
      else begin
        exp_in++;
        for (int b = 0; b < nbeats; b++) begin
          e.data = beats[b];
          e.last = (b == nbeats - 1);
          e.keep = e.last ? keepOf(64 - last_mty) : '1;
          e.size = 16'(64 * (nbeats - 1) + 64 - last_mty);
          e.src  = 16'(port * 2048 + qid);
          e.dst  = 16'(64 * (2 ** port));
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_drained"}, word_t'(exp_q.size()), word_t'(0));
    checkOutput({tag, "_pkt_in"}, word_t'(stat_in), word_t'(exp_in));
    checkOutput({tag, "_pkt_drop"}, word_t'(stat_drop), word_t'(exp_drop));
  endtask

  // Output monitor: every accepted beat against the model, held values during stalls.
  logic          stalled = 1'b0;
  logic [DW-1:0] held_data;
  logic [KW-1:0] held_keep;
  logic [48:0]   held_user;
  always @(negedge clk) begin
    beat_t e;
    if (axis_rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_data", word_t'(m_tdata), word_t'(held_data));
        checkOutput("hold_keep", word_t'(m_tkeep), word_t'(held_keep));
        checkOutput("hold_user", word_t'({m_tlast, m_size, m_src, m_dst}), word_t'(held_user));
        checkOutput("hold_valid", word_t'(m_tvalid), word_t'(1));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", word_t'(1), word_t'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", word_t'(m_tdata), word_t'(e.data));
          checkOutput("out_keep", word_t'(m_tkeep), word_t'(e.keep));
          checkOutput("out_last", word_t'(m_tlast), word_t'(e.last));
          checkOutput("out_size", word_t'(m_size), word_t'(e.size));
          checkOutput("out_src", word_t'(m_src), word_t'(e.src));
          checkOutput("out_dst", word_t'(m_dst), word_t'(e.dst));
        end
      end
      stalled   <= m_tvalid && !m_tready;
      held_data <= m_tdata;
      held_keep <= m_tkeep;
      held_user <= {m_tlast, m_size, m_src, m_dst};
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    int total;
    axis_rst = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_mty    = '0;
    s_err    = 1'b0;
    s_zb     = 1'b0;
    s_qid    = '0;
    s_port   = '0;
    m_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tready", word_t'(s_tready), word_t'(0));
    checkOutput("reset_outputs", word_t'({m_tvalid, m_tlast, m_tkeep, m_size, m_src, m_dst}), word_t'(0));
    checkOutput("reset_counters", word_t'({stat_in, stat_drop}), word_t'(0));
    @(posedge clk); #1;
    axis_rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_reset", word_t'(s_tready), word_t'(1));

    // Single-beat packet, qid 5 port 1: first output exactly two cycles after tlast
    applyStimulus(1, 0, 5, 1, -1, 1'b0, 0, stalls);
    @(negedge clk);
    checkOutput("latency_n1_valid", word_t'(m_tvalid), word_t'(0));
    @(negedge clk);
    checkOutput("latency_n2_valid", word_t'(m_tvalid), word_t'(1));
    checkOutput("single_tuser", word_t'({m_size, m_src, m_dst}), word_t'({16'd64, 16'h0805, 16'h0080}));
    checkOutput("single_keep_last", word_t'({m_tkeep, m_tlast}), word_t'({{KW{1'b1}}, 1'b1}));
    waitDrain("single");

    // Three beats with 22 empty bytes at the end
    applyStimulus(3, 22, 11'h3A1, 6, -1, 1'b0, 0, stalls);
    waitDrain("three_beat");

    // Error on beat 2 drops the packet; the clean one behind it passes
    applyStimulus(2, 0, 7, 2, 1, 1'b0, 0, stalls);
    applyStimulus(1, 10, 9, 3, -1, 1'b0, 0, stalls);
    waitDrain("err_drop");

    // Zero-byte flagged packet is dropped
    applyStimulus(1, 63, 12, 0, -1, 1'b1, 0, stalls);
    waitDrain("zero_byte");

    // 65-beat packet is swallowed without backpressure, then normal traffic resumes
    applyStimulus(65, 0, 100, 4, -1, 1'b0, 0, stalls);
    checkOutput("oversize_no_stall", word_t'(stalls), word_t'(0));
    waitDrain("oversize");
    applyStimulus(1, 0, 101, 4, -1, 1'b0, 0, stalls);
    waitDrain("after_oversize");
    applyStimulus(64, 0, 102, 5, -1, 1'b0, 0, stalls);
    waitDrain("max_packet");

    // Sink blocked: descriptor FIFO fills after eight packets
    m_tready = 1'b0;
    total = 0;
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1, $urandom_range(0, 63), $urandom_range(0, 2047), $urandom_range(0, 7),
                    -1, 1'b0, 0, stalls);
      total += stalls;
    end
    checkOutput("eight_no_stall", word_t'(total), word_t'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("desc_full_tready", word_t'(s_tready), word_t'(0));
    stim_done = 1'b0;
    fork
      begin
        applyStimulus(1, 5, 77, 7, -1, 1'b0, 0, stalls);
        stim_done = 1'b1;
      end
      begin
        for (int i = 0; i < 600; i++) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
          if (stim_done && exp_q.size() == 0) break;
        end
        m_tready = 1'b1;
      end
    join
    waitDrain("nine_stalled");

    // Random packets with random sink backpressure
    stim_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int nb;
          nb = $urandom_range(1, 6);
          applyStimulus(nb, $urandom_range(0, 63), $urandom_range(0, 2047), $urandom_range(0, 7),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1,
                        ($urandom_range(0, 9) == 0), 0, stalls);
        end
        stim_done = 1'b1;
      end
      begin
        for (int i = 0; i < 20000 && !stim_done; i++) begin
          @(posedge clk); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
      end
    join
    waitDrain("random");

    // Reset with a stalled output packet and a half-received input packet
    m_tready = 1'b0;
    applyStimulus(1, 0, 33, 1, -1, 1'b0, 0, stalls);
    applyStimulus(3, 0, 34, 2, -1, 1'b0, 2, stalls);
    @(posedge clk); #1;
    axis_rst = 1'b1;
    exp_q.delete();
    exp_in = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    axis_rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_counters", word_t'({stat_in, stat_drop}), word_t'(0));
    checkOutput("post_reset_valid", word_t'(m_tvalid), word_t'(0));
    repeat (6) @(posedge clk);
    applyStimulus(3, 17, 35, 3, -1, 1'b0, 0, stalls);
    waitDrain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/qdma_h2c_pkt_buffer.md
# qdma_h2c_pkt_buffer

Store-and-forward packet buffer between the QDMA H2C stream and the Menshen/OpenNIC user pipeline input. Accepts 512-bit H2C beats with QDMA sideband (mty, err, zero_byte, qid, port_id) and converts mty to tkeep. Drops erroneous, zero-byte and oversized packets before they reach the parser. Emits whole packets with OpenNIC-style tuser_size/src/dst, valid from the first beat, plus saturating packet/drop counters.

## Interface
- DATA_WIDTH, 512, stream data width (bits)
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat
- BUF_AW, 6, log2 of beat buffer depth (64 beats)
- DESC_AW, 3, log2 of packet descriptor FIFO depth (8 packets)

Ports:
- axis_aclk  in  1  single clock
- axis_rst  in  1  synchronous, active-high reset
- s_axis_h2c_tdata  in  DATA_WIDTH  beat data, byte 0 in bits [7:0]
- s_axis_h2c_tvalid / s_axis_h2c_tready  in / out  1  input handshake
- s_axis_h2c_tlast  in  1  last beat of packet
- s_axis_h2c_tuser_mty  in  6  empty bytes on last beat (ignored otherwise)
- s_axis_h2c_tuser_err  in  1  beat error flag
- s_axis_h2c_tuser_zero_byte  in  1  zero-length packet flag
- s_axis_h2c_tuser_qid  in  11  queue id, sampled on first beat
- s_axis_h2c_tuser_port_id  in  3  port id, sampled on first beat
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tlast  out  1  last beat
- m_axis_tuser_size  out  16  packet length in bytes, constant across packet
- m_axis_tuser_src  out  16  {2'b0, port_id, qid}
- m_axis_tuser_dst  out  16  16'h0040 << port_id
- stat_pkt_in  out  32  packets forwarded, saturating
- stat_pkt_drop  out  32  packets dropped, saturating

## Operation
- Beat RAM: 2^BUF_AW entries of {tdata, tlast, mty}. Descriptor FIFO: 2^DESC_AW entries of {size, src, dst}.
- Write FSM states: IDLE (await first beat), BODY, DROP.
- IDLE: on a handshake, latch qid/port, set err_acc = err | zero_byte, write beat at spec_wr_ptr, beat_cnt = 1. Without tlast go to BODY. With tlast resolve immediately (see below).
- BODY: write each beat, OR err/zero_byte into err_acc, increment beat_cnt.
- Resolve on the tlast beat:
  - err_acc set: spec_wr_ptr rewinds to commit_wr_ptr, stat_pkt_drop++.
  - Otherwise: push descriptor, commit_wr_ptr = spec_wr_ptr + 1, stat_pkt_in++.
- Size arithmetic: size = 64*(beat_cnt-1) + (64-mty), computed in 16 bits (max 4096).
- Oversize: a beat that would make the packet span 2^BUF_AW beats without tlast triggers rewind and DROP. DROP keeps tready=1 and discards beats through tlast, counts one drop, then returns to IDLE.
- s_axis_h2c_tready = !rst && state!=DROP ? (RAM not full vs rd_ptr) && (descriptor FIFO not full) : (state==DROP).
- Read FSM states: IDLE, SEND.
  - IDLE: when a descriptor is present, prefetch the first beat, load the tuser registers, go to SEND.
  - SEND: present beats. m_axis_tkeep = {KEEP_WIDTH{1'b1}} >> mty on the last beat, all ones otherwise.
  - On the tlast handshake, pop the descriptor and return to IDLE. Back-to-back packets are allowed with one bubble max.
- Counters saturate at 32'hFFFFFFFF.

## Timing
- Reset values: tready 0 during reset, 1 on the first cycle after. m_axis_tvalid 0, tlast 0, tkeep 0, tuser_* 0. Counters 0. All pointers 0. FSMs in IDLE.
- Latency: if the input tlast handshake occurs at cycle N, m_axis_tvalid for that packet's first beat asserts at N+2 at the earliest. No output before tlast is accepted.
- While tvalid && !tready: tdata/tkeep/tlast/tuser_* held stable. Throughput 1 beat/cycle within a packet.
- Simultaneous descriptor push and pop: both take effect. FIFO occupancy unchanged.
- Simultaneous write and read at full RAM: tready is computed from registered pointers, so a read freeing space re-enables tready the next cycle.
- Reset mid-operation: partial input packets and in-flight output packets are discarded without counter updates.

## Test plan
- Single-beat packet, mty=0, qid=5, port=1 -> one beat at N+2: tkeep all ones, tlast=1, size=64, src=16'h0805, dst=16'h0080, stat_pkt_in=1.
- 3-beat packet, last mty=22 -> 3 beats with data matching input. Last tkeep=64'h0000_03FF_FFFF_FFFF. size=170.
- 2-beat packet with tuser_err on beat 2, then a clean 1-beat packet -> only the clean packet is output. stat_pkt_drop=1, stat_pkt_in=1.
- 65-beat packet (BUF_AW=6) -> all 65 beats accepted (tready stays 1), no output, stat_pkt_drop=1. A following 64B packet passes.
- m_axis_tready held 0 while nine 1-beat packets are sent -> tready drops after the 8th descriptor. Then m_axis_tready toggles 50% -> all 9 packets emerge in order with stable data during stalls.
- axis_rst pulsed mid-way through a 3-beat input packet -> no output, counters 0, the next packet is forwarded correctly.
